// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the vehicle detector side and the conditioner.
// master: drives the raw detector and clear strobes, observes conditioned outputs.
// slave:  the conditioner itself.
interface sensor_conditioner_if #(
  parameter int CNT_W = 8
);
  logic             raw_sensor;
  logic             clr_fault;
  logic             clr_cnt;
  logic             sensor;
  logic             car_pulse;
  logic [CNT_W-1:0] car_cnt;
  logic             fault;

  modport master (
    output raw_sensor, clr_fault, clr_cnt,
    input  sensor, car_pulse, car_cnt, fault
  );

  modport slave (
    input  raw_sensor, clr_fault, clr_cnt,
    output sensor, car_pulse, car_cnt, fault
  );
endinterface

// File: rtl/sensor_conditioner.sv
// Country-road vehicle detector conditioner: 2-flop synchronizer, debounce,
// minimum-hold stretcher, stuck-high fault latch and saturating vehicle counter.
// Everything runs on spi_sclk with a synchronous active-high reset.
module sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int HOLD_CYCLES  = 8,
  parameter int STUCK_CYCLES = 200,
  parameter int CNT_W        = 8
) (
  input  logic                spi_sclk,
  input  logic                rst,
  sensor_conditioner_if.slave bus
);

  localparam int DEB_W   = $clog2(DEB_CYCLES);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES);
  localparam int STUCK_W = $clog2(STUCK_CYCLES);

  localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_PRESENT = 3'd2,
    S_HOLD    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  logic               sync1_q, sync2_q;
  state_t             state_q;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [STUCK_W-1:0] stuck_cnt_q;
  logic               car_pulse_q;
  logic [CNT_W-1:0]   car_cnt_q, car_cnt_d;
  logic               s;
  logic               accept;

  // Two-flop synchronizer for the asynchronous detector input.
  // NOTE: non-blocking assignments make sync2_q take sync1_q's pre-edge value,
  // which is what forms the two-stage chain; blocking here would collapse it.
  always_ff @(posedge spi_sclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.raw_sensor;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  // A vehicle is accepted on the edge that completes debounce qualification.
  assign accept = (state_q == S_ARM) && s && (deb_cnt_q == DEB_LAST);

  // Next vehicle count: clear beats increment, increment saturates.
  // NOTE: the default assignment first keeps this block purely combinational;
  // leaving car_cnt_d unassigned on some path would infer a latch.
  always_comb begin
    car_cnt_d = car_cnt_q;
    if (bus.clr_cnt) begin
      car_cnt_d = '0;
    end else if (accept && (car_cnt_q != CNT_MAX)) begin
      car_cnt_d = car_cnt_q + 1'b1;
    end
  end

  // Detector FSM with its debounce/hold/stuck counters and registered pulse/count.
  always_ff @(posedge spi_sclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      stuck_cnt_q <= '0;
      car_pulse_q <= 1'b0;
      car_cnt_q   <= '0;
    end else begin
      car_pulse_q <= 1'b0;
      car_cnt_q   <= car_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (s) begin
            state_q   <= S_ARM;
            deb_cnt_q <= DEB_ONE;
          end
        end
        S_ARM: begin
          // Any low sample while qualifying is bounce: start over.
          if (!s) begin
            state_q <= S_IDLE;
          end else if (deb_cnt_q == DEB_LAST) begin
            state_q     <= S_PRESENT;
            stuck_cnt_q <= '0;
            car_pulse_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        S_PRESENT: begin
          if (!s) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= HOLD_ONE;
          end else if (stuck_cnt_q == STUCK_LAST) begin
            state_q <= S_FAULT;
          end else begin
            stuck_cnt_q <= stuck_cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          // A re-rise during hold is the same vehicle: no new pulse or count.
          if (s) begin
            state_q     <= S_PRESENT;
            stuck_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q <= S_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        S_FAULT: begin
          // Clearing is only safe once the detector has actually released.
          if (bus.clr_fault && !s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sensor    = (state_q == S_PRESENT) || (state_q == S_HOLD);
  assign bus.fault     = (state_q == S_FAULT);
  assign bus.car_pulse = car_pulse_q;
  assign bus.car_cnt   = car_cnt_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a run-length reference model predicts every output each cycle,
// and directed steps add fixed-value checks on latency, bounce, fault and counting.
module tb_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 200;

  logic spi_sclk = 1'b0;
  logic rst;

  sensor_conditioner_if #(.CNT_W(8)) if8 ();
  sensor_conditioner_if #(.CNT_W(2)) if2 ();

  sensor_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .STUCK_CYCLES(STUCK), .CNT_W(8)
  ) dut8 (
    .spi_sclk(spi_sclk),
    .rst     (rst),
    .bus     (if8)
  );

  sensor_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .STUCK_CYCLES(STUCK), .CNT_W(2)
  ) dut2 (
    .spi_sclk(spi_sclk),
    .rst     (rst),
    .bus     (if2)
  );

  always #5 spi_sclk = ~spi_sclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: synchronizer delay line plus run lengths of the synced level.
  bit m_s1, m_s2;
  int m_qual;     // consecutive high samples while waiting for a vehicle
  bit m_veh;      // vehicle being reported (sensor high)
  int m_low;      // consecutive low samples during a vehicle
  int m_hi;       // high samples since the vehicle (re)started
  bit m_fault;
  bit m_pulse;
  int m_cnt8, m_cnt2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit raw, input bit cf, input bit cc, input bit r);
    bit s;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_qual = 0; m_veh = 0; m_low = 0; m_hi = 0;
      m_fault = 0; m_pulse = 0; m_cnt8 = 0; m_cnt2 = 0;
      return;
    end
    s = m_s2;
    m_pulse = 0;
    if (m_fault) begin
      if (cf && !s) m_fault = 0;
    end else if (m_veh) begin
      if (!s) begin
        m_low++;
        if (m_low == HOLD) begin
          m_veh = 0;
          m_low = 0;
        end
      end else if (m_low > 0) begin
        m_low = 0;
        m_hi  = 0;
      end else begin
        m_hi++;
        if (m_hi == STUCK) begin
          m_veh   = 0;
          m_fault = 1;
        end
      end
    end else if (s) begin
      m_qual++;
      if (m_qual == DEB) begin
        m_qual  = 0;
        m_veh   = 1;
        m_hi    = 0;
        m_low   = 0;
        m_pulse = 1;
      end
    end else begin
      m_qual = 0;
    end
    if (cc) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (m_pulse) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  // One clock: apply inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cycle(input bit raw, input bit cf, input bit cc, input bit r);
    rst = r;
    if8.raw_sensor = raw; if8.clr_fault = cf; if8.clr_cnt = cc;
    if2.raw_sensor = raw; if2.clr_fault = cf; if2.clr_cnt = cc;
    @(posedge spi_sclk);
    model_step(raw, cf, cc, r);
    #1;
    check("sensor8", 32'(if8.sensor),    32'(m_veh));
    check("pulse8",  32'(if8.car_pulse), 32'(m_pulse));
    check("cnt8",    32'(if8.car_cnt),   32'(m_cnt8));
    check("fault8",  32'(if8.fault),     32'(m_fault));
    check("sensor2", 32'(if2.sensor),    32'(m_veh));
    check("cnt2",    32'(if2.car_cnt),   32'(m_cnt2));
  endtask

  initial begin
    int fault_edge;
    int pulses;
    bit saw_hi;
    int exp2 [5];
    exp2 = '{1, 2, 3, 3, 3};

    // Reset with the detector already high: everything stays clear.
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("rst_sensor", 32'(if8.sensor), 0);
    check("rst_fault",  32'(if8.fault),  0);
    check("rst_cnt",    32'(if8.car_cnt), 0);

    // Rise latency: sensor first high after edge DEB+1, pulse on that same edge.
    for (int e = 0; e <= 6; e++) begin
      cycle(1, 0, 0, 0);
      check("lat_rise",  32'(if8.sensor),    32'(e >= 5));
      check("lat_pulse", 32'(if8.car_pulse), 32'(e == 5));
    end
    // Fall latency: sensor low after edge HOLD+1.
    for (int e = 0; e <= 10; e++) begin
      cycle(0, 0, 0, 0);
      check("lat_fall", 32'(if8.sensor), 32'(e < 9));
    end
    check("cnt_first", 32'(if8.car_cnt), 1);

    // Bounce: 3 high / 1 low never qualifies.
    saw_hi = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        cycle(j < 3, 0, 0, 0);
        saw_hi |= if8.sensor;
      end
    end
    for (int j = 0; j < 4; j++) cycle(0, 0, 0, 0);
    check("bounce_sensor", 32'(saw_hi), 0);
    check("bounce_cnt", 32'(if8.car_cnt), 1);

    // Short gap inside one vehicle: a single pulse only.
    pulses = 0;
    for (int j = 0; j < 49; j++) begin
      cycle((j < 20) || (j >= 24 && j < 34), 0, 0, 0);
      pulses += int'(if8.car_pulse);
    end
    check("gap_pulses", 32'(pulses), 1);
    check("gap_cnt", 32'(if8.car_cnt), 2);

    // Stuck detector: fault on edge 205; clr_fault ignored while still high.
    fault_edge = -1;
    for (int e = 0; e < 300; e++) begin
      cycle(1, (e >= 250 && e < 260), 0, 0);
      if (fault_edge < 0 && if8.fault) fault_edge = e;
    end
    check("stuck_edge", 32'(fault_edge), 205);
    check("stuck_fault", 32'(if8.fault), 1);
    check("stuck_sensor", 32'(if8.sensor), 0);
    for (int j = 0; j < 3; j++) cycle(0, 0, 0, 0);
    check("fault_held", 32'(if8.fault), 1);
    cycle(0, 1, 0, 0);
    check("fault_clr", 32'(if8.fault), 0);

    // Saturation on the 2-bit counter, then clear coincident with a pulse.
    cycle(0, 0, 1, 0);
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 24; j++) cycle(j < 12, 0, 0, 0);
      check("sat_cnt2", 32'(if2.car_cnt), 32'(exp2[v]));
      check("sat_cnt8", 32'(if8.car_cnt), 32'(v + 1));
    end
    for (int e = 0; e <= 5; e++) cycle(1, 0, (e == 5), 0);
    check("clr_pulse", 32'(if2.car_pulse), 1);
    check("clr_cnt2", 32'(if2.car_cnt), 0);
    check("clr_cnt8", 32'(if8.car_cnt), 0);

    // Reset while in HOLD.
    for (int j = 0; j < 12; j++) cycle(0, 0, 0, 0);
    for (int j = 0; j < 10; j++) cycle(1, 0, 0, 0);
    for (int j = 0; j < 3; j++) cycle(0, 0, 0, 0);
    check("hold_sensor", 32'(if8.sensor), 1);
    cycle(0, 0, 0, 1);
    check("rst_hold_sensor", 32'(if8.sensor), 0);
    check("rst_hold_cnt", 32'(if8.car_cnt), 0);

    // Reset while in FAULT.
    for (int j = 0; j < 215; j++) cycle(1, 0, 0, 0);
    check("pre_rst_fault", 32'(if8.fault), 1);
    cycle(1, 0, 0, 1);
    check("rst_fault_fault", 32'(if8.fault), 0);
    check("rst_fault_sensor", 32'(if8.sensor), 0);
    check("rst_fault_cnt", 32'(if8.car_cnt), 0);

    // Randomized runs of levels, occasional long stuck periods, strobes and resets.
    for (int n = 0; n < 3000; ) begin
      bit lvl;
      int len;
      lvl = bit'($urandom_range(0, 1));
      len = ($urandom_range(0, 39) == 0) ? 250 : int'($urandom_range(1, 12));
      for (int j = 0; j < len; j++) begin
        cycle(lvl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 499) == 0));
        n++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
